// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Asynchronous serial receiver, 8N1, LSB first. It receives the host link for
//   the command parser. The RX pin is synchronized into the clk domain. Each bit
//   is timed with a per-bit counter and sampled at mid-bit. A good byte gives a
//   one-cycle valid strobe. A stop bit sampled low gives a one-cycle framing
//   error strobe.
//
//   Optional feature (compile-time macro):
//     UART_RX_MAJORITY_EN  -- every bit decision (start, data, stop) is the
//                             2-of-3 majority of the synchronized line at cycles
//                             target-2, target-1 and target. Decision timing is
//                             the same as the single-sample build.
//
// Parameters:
//   clk_freq    input clock frequency in Hz
//   baudrate    line rate in bit/s
//   timebase    clock cycles per bit (16-bit range, must be >= 8)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   i_rx         serial line, idle high, asynchronous to clk
//   o_rx_byte    last correctly received byte, held until the next good byte
//   o_rx_valid   one-cycle pulse: o_rx_byte was updated this cycle
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_busy       high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned clk_freq = 12000000,
  parameter int unsigned baudrate = 115200,
  parameter int unsigned timebase = clk_freq / baudrate
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  // The start bit is sampled half a bit after its edge, so the later samples
  // land near the middle of each bit.
  localparam logic [15:0] half_target = 16'((timebase / 2) - 1);
  localparam logic [15:0] bit_target  = 16'(timebase - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] ctr;
  logic [15:0] ctr_next;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_next;
  logic [7:0]  shift;
  logic [7:0]  shift_next;
  logic [7:0]  rx_byte_next;
  logic        rx_valid_next;
  logic        frame_err_next;

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detector. All three stages reset to the idle
  // level, so releasing reset can never look like a start edge.
  // ---------------------------------------------------------------------------
  logic sync1;
  logic sync2;
  logic prev;
  logic fell;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      // NOTE: all clocked state uses non-blocking assignments. Each register
      // then reads the values from before the edge, so the stages shift by
      // one each cycle and do not collapse into a single stage.
      sync1 <= i_rx;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fell = prev & ~sync2;

  // ---------------------------------------------------------------------------
  // Bit value at the sample point
  // ---------------------------------------------------------------------------
  logic bit_val;

`ifdef UART_RX_MAJORITY_EN
  // hist[0] holds the synchronized line one cycle ago and hist[1] two cycles
  // ago. Together with sync2, the vote covers target-2 .. target.
  logic [1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], sync2};
    end
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & sync2) | (hist[0] & sync2);
`else
  assign bit_val = sync2;
`endif

  // ---------------------------------------------------------------------------
  // Sample point: half a bit into the start bit, a full bit for the rest.
  // ---------------------------------------------------------------------------
  logic at_target;

  assign at_target = (state == ST_START) ? (ctr == half_target)
                                         : (ctr == bit_target);

  // ---------------------------------------------------------------------------
  // FSM: state register and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ctr         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_rx_byte   <= '0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_next;
      ctr         <= ctr_next;
      bit_idx     <= bit_idx_next;
      shift       <= shift_next;
      o_rx_byte   <= rx_byte_next;
      o_rx_valid  <= rx_valid_next;
      o_frame_err <= frame_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first. Each path then
    // assigns all of them, so no latch is inferred and the pulses drop back to
    // zero on their own.
    state_next     = state;
    ctr_next       = ctr + 16'd1;
    bit_idx_next   = bit_idx;
    shift_next     = shift;
    rx_byte_next   = o_rx_byte;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;

    unique case (state)
      ST_IDLE: begin
        ctr_next = '0;
        if (fell) begin
          state_next = ST_START;
        end
      end

      ST_START: begin
        if (at_target) begin
          ctr_next = '0;
          if (!bit_val) begin
            state_next   = ST_DATA;
            bit_idx_next = '0;
          end else begin
            // The line was high again at mid-start: treat it as a glitch.
            state_next = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (at_target) begin
          ctr_next     = '0;
          // LSB arrives first: shift in at the top so that after eight
          // samples the first bit has reached bit 0.
          shift_next   = {bit_val, shift[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_next = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        if (at_target) begin
          ctr_next = '0;
          if (bit_val) begin
            rx_byte_next  = shift;
            rx_valid_next = 1'b1;
            // Back to idle at mid-stop-bit, so a start edge right after the
            // stop bit is still caught.
            state_next    = ST_IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        // A held break reports a single framing error. Wait here until the
        // line is released.
        ctr_next = '0;
        if (sync2) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        ctr_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_busy = (state != ST_IDLE);

endmodule
